// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read-address/read-data channel pair between
// the icache and dcache refill ports. Round-robin grant, one outstanding read
// per requester, R beats steered back to their owner by ID. Data reads wait
// until the write path has drained.
module axi_rd_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [3:0]  INST_ID    = 4'd0,
  parameter logic [3:0]  DATA_ID    = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_ret_data,
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_ret_data,
  input  logic        wr_idle,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;

  ar_state_t   state_q, state_d;
  logic        inst_busy, data_busy;
  logic        last_grant_data;
  logic        rready_q;
  logic        rd_err_q;
  logic        inst_cand, data_cand;
  logic        grant_inst, grant_data;
  logic        inst_hit, data_hit;
  logic        beat_taken;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;
  logic        unused_rresp;

  // Response codes carry no information this block acts on.
  assign unused_rresp = ^rresp;

  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = rready_q;
  assign rd_err  = rd_err_q;

  // AR state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= AR_IDLE;
    else         state_q <= state_d;
  end

  // Grant selection and AR handshake; ties go to whoever was not granted last.
  always_comb begin
    state_d    = state_q;
    arvalid    = 1'b0;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    inst_cand  = inst_rd_req && !inst_busy;
    data_cand  = data_rd_req && !data_busy && wr_idle;
    case (state_q)
      AR_IDLE: begin
        if (resetn) begin
          if (inst_cand && data_cand) begin
            grant_data = !last_grant_data;
            grant_inst = last_grant_data;
          end else begin
            grant_inst = inst_cand;
            grant_data = data_cand;
          end
          if (grant_inst || grant_data) state_d = AR_SEND;
        end
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign inst_rd_rdy = grant_inst;
  assign data_rd_rdy = grant_data;
  assign sel_type    = grant_data ? data_rd_type : inst_rd_type;
  assign sel_addr    = grant_data ? data_rd_addr : inst_rd_addr;

  // Latch the AR fields of the granted request; they stay put through AR_SEND.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      araddr <= 32'd0;
      arlen  <= 8'd0;
      arsize <= 3'd0;
      arid   <= 4'd0;
    end else if (grant_inst || grant_data) begin
      araddr <= sel_addr;
      arlen  <= sel_type[2] ? LINE_LEN : 8'd0;
      arsize <= sel_type[2] ? 3'd2 : {1'b0, sel_type[1:0]};
      arid   <= grant_data ? DATA_ID : INST_ID;
    end
  end

  // Round-robin memory: remembers whether the last grant went to data.
  always_ff @(posedge clk) begin
    if (!resetn)                        last_grant_data <= 1'b0;
    else if (grant_inst || grant_data)  last_grant_data <= grant_data;
  end

  assign beat_taken = rvalid && rready_q;
  assign inst_hit   = beat_taken && (rid == INST_ID) && inst_busy;
  assign data_hit   = beat_taken && (rid == DATA_ID) && data_busy;

  assign inst_ret_valid = inst_hit;
  assign inst_ret_last  = inst_hit && rlast;
  assign inst_ret_data  = rdata;
  assign data_ret_valid = data_hit;
  assign data_ret_last  = data_hit && rlast;
  assign data_ret_data  = rdata;

  // Busy flags: set on grant, cleared by the owner's last beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
    end else begin
      if (grant_inst)              inst_busy <= 1'b1;
      else if (inst_hit && rlast)  inst_busy <= 1'b0;
      if (grant_data)              data_busy <= 1'b1;
      else if (data_hit && rlast)  data_busy <= 1'b0;
    end
  end

  // rready comes up after reset; rd_err latches any beat nobody owns.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rready_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      rready_q <= 1'b1;
      if (beat_taken && !inst_hit && !data_hit) rd_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed stimulus with a per-cycle reference model of
// the arbiter's externally visible behaviour plus literal spot checks.
module tb_axi_rd_arbiter;

  localparam logic [3:0] ID_OF [2] = '{4'd0, 4'd1};
  localparam logic [7:0] LINE_LEN_EXP = 8'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_rd_req, data_rd_req;
  logic [2:0]  inst_rd_type, data_rd_type;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_rdy, data_rd_rdy;
  logic        inst_ret_valid, inst_ret_last, data_ret_valid, data_ret_last;
  logic [31:0] inst_ret_data, data_ret_data;
  logic        wr_idle;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rd_err;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .data_ret_data(data_ret_data),
    .wr_idle(wr_idle),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state: what the outside world should see.
  bit          m_valid = 0;
  bit          m_pend;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  bit          m_busy [2];
  bit          m_last_was_data;
  bit          m_err;
  bit          m_rready;
  bit          cand [2];
  bit          hit [2];
  int          win;
  logic [2:0]  req_type [2];
  logic [31:0] req_addr [2];

  // Compare process: mid-cycle, check outputs against the model, then advance it.
  always @(negedge clk) begin
    if (!resetn) begin
      m_valid = 1; m_pend = 0; m_busy[0] = 0; m_busy[1] = 0;
      m_last_was_data = 0; m_err = 0; m_rready = 0;
    end else if (m_valid) begin
      req_type[0] = inst_rd_type; req_type[1] = data_rd_type;
      req_addr[0] = inst_rd_addr; req_addr[1] = data_rd_addr;
      cand[0] = !m_pend && inst_rd_req && !m_busy[0];
      cand[1] = !m_pend && data_rd_req && !m_busy[1] && wr_idle;
      if (cand[0] && cand[1]) win = m_last_was_data ? 0 : 1;
      else if (cand[0])       win = 0;
      else if (cand[1])       win = 1;
      else                    win = -1;
      check_output("inst_rd_rdy", inst_rd_rdy, win == 0);
      check_output("data_rd_rdy", data_rd_rdy, win == 1);
      check_output("arvalid", arvalid, m_pend);
      check_output("arburst", arburst, 2'b01);
      if (m_pend) begin
        check_output("arid", arid, m_id);
        check_output("araddr", araddr, m_addr);
        check_output("arlen", arlen, m_len);
        check_output("arsize", arsize, m_size);
      end
      check_output("rready", rready, m_rready);
      for (int k = 0; k < 2; k++)
        hit[k] = m_rready && rvalid && (rid == ID_OF[k]) && m_busy[k];
      check_output("inst_ret_valid", inst_ret_valid, hit[0]);
      check_output("data_ret_valid", data_ret_valid, hit[1]);
      if (hit[0]) begin
        check_output("inst_ret_last", inst_ret_last, rlast);
        check_output("inst_ret_data", inst_ret_data, rdata);
      end
      if (hit[1]) begin
        check_output("data_ret_last", data_ret_last, rlast);
        check_output("data_ret_data", data_ret_data, rdata);
      end
      check_output("rd_err", rd_err, m_err);
      if (win >= 0) begin
        m_pend = 1;
        m_id   = ID_OF[win];
        m_addr = req_addr[win];
        m_len  = (req_type[win] == 3'b100) ? LINE_LEN_EXP : 8'd0;
        m_size = (req_type[win] == 3'b100) ? 3'd2 : {1'b0, req_type[win][1:0]};
        m_busy[win] = 1;
        m_last_was_data = (win == 1);
      end else if (m_pend && arready) begin
        m_pend = 0;
      end
      for (int k = 0; k < 2; k++)
        if (hit[k] && rlast) m_busy[k] = 0;
      if (m_rready && rvalid && !hit[0] && !hit[1]) m_err = 1;
      m_rready = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] beat_id, input logic [31:0] beat_data,
                                input logic beat_last);
    rvalid = 1'b1; rid = beat_id; rdata = beat_data; rlast = beat_last;
  endtask

  initial begin
    resetn = 0; inst_rd_req = 0; data_rd_req = 0;
    inst_rd_type = 3'b000; data_rd_type = 3'b000;
    inst_rd_addr = 32'd0; data_rd_addr = 32'd0;
    wr_idle = 1; arready = 0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
    rlast = 0; rvalid = 0;
    repeat (3) tick();

    // Reset values and rready rising one cycle after release.
    resetn = 1; #1;
    check_output("reset rready", rready, 1'b0);
    check_output("reset arvalid", arvalid, 1'b0);
    check_output("reset rd_err", rd_err, 1'b0);
    check_output("reset araddr", araddr, 32'd0);
    check_output("reset arburst", arburst, 2'b01);
    tick();
    check_output("rready up", rready, 1'b1);

    // Instruction line read and its four-beat return.
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h1C00_0000; #1;
    check_output("line rdy", inst_rd_rdy, 1'b1);
    tick(); inst_rd_req = 0;
    data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h80; #1;
    check_output("line arvalid", arvalid, 1'b1);
    check_output("line arid", arid, 4'd0);
    check_output("line arlen", arlen, 8'd3);
    check_output("line arsize", arsize, 3'd2);
    check_output("line araddr", araddr, 32'h1C00_0000);
    check_output("no rdy in send", data_rd_rdy, 1'b0);
    tick(); data_rd_req = 0; arready = 1;
    tick(); arready = 0; #1;
    check_output("line ar done", arvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'd0, 32'hA000_0000 + 32'(i), i == 3); #1;
      check_output("line beat data", inst_ret_data, 32'hA000_0000 + 32'(i));
      check_output("line beat last", inst_ret_last, i == 3);
      check_output("line no crosstalk", data_ret_valid, 1'b0);
      tick();
    end
    rvalid = 0; rlast = 0;
    inst_rd_req = 1; inst_rd_type = 3'b010; #1;
    check_output("reissue rdy", inst_rd_rdy, 1'b1);
    inst_rd_req = 0;
    tick();
    check_output("dropped req", arvalid, 1'b0);

    // Tie from reset: data first, then inst, then data again.
    resetn = 0; tick(); resetn = 1; tick();
    inst_rd_req = 1; inst_rd_type = 3'b010; inst_rd_addr = 32'h100;
    data_rd_req = 1; data_rd_type = 3'b100; data_rd_addr = 32'h200; #1;
    check_output("tie1 data rdy", data_rd_rdy, 1'b1);
    check_output("tie1 inst rdy", inst_rd_rdy, 1'b0);
    tick(); data_rd_req = 0; arready = 1; #1;
    check_output("tie1 arid", arid, 4'd1);
    tick(); arready = 0; #1;
    check_output("inst after data", inst_rd_rdy, 1'b1);
    tick(); inst_rd_req = 0; arready = 1; #1;
    check_output("inst arid", arid, 4'd0);
    check_output("inst araddr", araddr, 32'h100);
    tick(); arready = 0;
    apply_stimulus(4'd1, 32'hD1, 1'b0); tick();
    apply_stimulus(4'd0, 32'hC1, 1'b0); #1;
    check_output("interleave inst", inst_ret_data, 32'hC1);
    tick();
    apply_stimulus(4'd1, 32'hD2, 1'b1); #1;
    check_output("interleave data last", data_ret_last, 1'b1);
    check_output("interleave quiet", inst_ret_valid, 1'b0);
    tick();
    apply_stimulus(4'd0, 32'hC2, 1'b1); tick();
    rvalid = 0; rlast = 0;
    inst_rd_req = 1; data_rd_req = 1; #1;
    check_output("tie2 data rdy", data_rd_rdy, 1'b1);
    check_output("tie2 inst rdy", inst_rd_rdy, 1'b0);
    tick(); data_rd_req = 0; arready = 1;
    tick(); tick(); inst_rd_req = 0;
    tick(); arready = 0;
    apply_stimulus(4'd1, 32'hD3, 1'b1); tick();
    apply_stimulus(4'd0, 32'hC3, 1'b1); tick();
    rvalid = 0; rlast = 0;

    // Data read held off by pending writes.
    wr_idle = 0; data_rd_req = 1; data_rd_type = 3'b010; data_rd_addr = 32'h300; #1;
    check_output("wr busy rdy", data_rd_rdy, 1'b0);
    tick();
    check_output("wr busy rdy2", data_rd_rdy, 1'b0);
    wr_idle = 1; #1;
    check_output("wr idle rdy", data_rd_rdy, 1'b1);
    tick(); data_rd_req = 0; arready = 1; #1;
    check_output("word arlen", arlen, 8'd0);
    check_output("word arsize", arsize, 3'd2);
    tick(); arready = 0;
    apply_stimulus(4'd1, 32'hD4, 1'b1); tick();
    rvalid = 0; rlast = 0;
    inst_rd_req = 1; inst_rd_type = 3'b001; inst_rd_addr = 32'h402; tick();
    inst_rd_req = 0; arready = 1; #1;
    check_output("half arsize", arsize, 3'd1);
    tick(); arready = 0;
    apply_stimulus(4'd0, 32'hC4, 1'b1); tick();
    rvalid = 0; rlast = 0;

    // Beat with an unknown ID is dropped and sets the sticky error.
    apply_stimulus(4'd3, 32'hEE, 1'b1); #1;
    check_output("bad id inst", inst_ret_valid, 1'b0);
    check_output("bad id data", data_ret_valid, 1'b0);
    tick(); rvalid = 0; rlast = 0;
    check_output("rd_err set", rd_err, 1'b1);
    tick(); tick();
    check_output("rd_err sticky", rd_err, 1'b1);

    // Reset in the middle of AR_SEND.
    inst_rd_req = 1; inst_rd_type = 3'b100; inst_rd_addr = 32'h400; tick();
    inst_rd_req = 0; #1;
    check_output("send before rst", arvalid, 1'b1);
    resetn = 0; tick(); resetn = 1; #1;
    check_output("rst arvalid", arvalid, 1'b0);
    check_output("rst rd_err", rd_err, 1'b0);
    tick();
    inst_rd_req = 1; inst_rd_addr = 32'h500; #1;
    check_output("post rst rdy", inst_rd_rdy, 1'b1);
    tick(); inst_rd_req = 0; arready = 1; #1;
    check_output("post rst araddr", araddr, 32'h500);
    tick(); arready = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
